mem_arbiter: RTL and testbench

//  Shares one single-ported, multi-cycle 16-bit memory between the fetch stage (instruction reads)
//  and the memory stage (data loads/stores) of the pipelined core. Data accesses have priority,

---
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported, multi-cycle 16-bit memory between instruction fetch and
// data loads/stores. Data wins, but fetch is forced in after STREAK_MAX back-to-back data grants.
module mem_arbiter #(
    parameter int STREAK_MAX = 3,
    parameter int TIMEOUT    = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_done,
    output logic        if_err,
    output logic        if_stall,
    input  logic        dm_rd,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_err,
    output logic        dm_stall,
    input  logic        halt,
    output logic        halted,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_busy,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} arbStateT;

    localparam logic [7:0] STREAK_LIM  = 8'(STREAK_MAX);
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

    arbStateT    stateReg, stateNext;
    logic        ownerDataReg, ownerDataNext;
    logic        opWrReg, opWrNext;
    logic [15:0] addrReg, addrNext;
    logic [15:0] wdataReg, wdataNext;
    logic        errReg, errNext;
    logic [7:0]  cntReg, cntNext;
    logic [7:0]  streakReg, streakNext;
    logic [15:0] ifRdataReg, ifRdataNext;
    logic [15:0] dmRdataReg, dmRdataNext;

    logic        dataPending;
    logic        fetchElig;
    logic        grantData;
    logic        grantAny;
    logic [15:0] grantAddr;
    logic        rejectNow;

    assign dataPending = dm_rd | dm_wr;
    assign fetchElig   = if_req & ~halt;

    always_comb begin
        stateNext     = stateReg;
        ownerDataNext = ownerDataReg;
        opWrNext      = opWrReg;
        addrNext      = addrReg;
        wdataNext     = wdataReg;
        errNext       = errReg;
        cntNext       = cntReg;
        streakNext    = streakReg;
        ifRdataNext   = ifRdataReg;
        dmRdataNext   = dmRdataReg;
        grantData     = 1'b0;
        grantAny      = 1'b0;
        grantAddr     = if_addr;
        rejectNow     = 1'b0;

        case (stateReg)
            S_IDLE: begin
                if (dataPending && ((streakReg < STREAK_LIM) || !fetchElig)) begin
                    grantData  = 1'b1;
                    grantAny   = 1'b1;
                    streakNext = fetchElig ? streakReg + 8'd1 : 8'd0;
                end else if (fetchElig) begin
                    grantAny   = 1'b1;
                    streakNext = 8'd0;
                end
                if (grantAny) begin
                    grantAddr     = grantData ? dm_addr : if_addr;
                    rejectNow     = grantAddr[0] | (grantData & dm_rd & dm_wr);
                    ownerDataNext = grantData;
                    opWrNext      = grantData & dm_wr;
                    addrNext      = grantAddr;
                    wdataNext     = grantData ? dm_wdata : 16'h0000;
                    errNext       = rejectNow;
                    stateNext     = rejectNow ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!mem_busy) begin
                    cntNext   = 8'd0;
                    stateNext = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_done) begin
                    // Stores leave the owner's read-data register untouched.
                    if (!opWrReg) begin
                        if (ownerDataReg) dmRdataNext = mem_rdata;
                        else              ifRdataNext = mem_rdata;
                    end
                    stateNext = S_RESP;
                end else begin
                    cntNext = cntReg + 8'd1;
                    if (cntReg + 8'd1 == TIMEOUT_LIM) begin
                        errNext   = 1'b1;
                        stateNext = S_RESP;
                    end
                end
            end
            S_RESP: stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg     <= S_IDLE;
            ownerDataReg <= 1'b0;
            opWrReg      <= 1'b0;
            addrReg      <= 16'h0000;
            wdataReg     <= 16'h0000;
            errReg       <= 1'b0;
            cntReg       <= 8'd0;
            streakReg    <= 8'd0;
            ifRdataReg   <= 16'h0000;
            dmRdataReg   <= 16'h0000;
        end else begin
            stateReg     <= stateNext;
            ownerDataReg <= ownerDataNext;
            opWrReg      <= opWrNext;
            addrReg      <= addrNext;
            wdataReg     <= wdataNext;
            errReg       <= errNext;
            cntReg       <= cntNext;
            streakReg    <= streakNext;
            ifRdataReg   <= ifRdataNext;
            dmRdataReg   <= dmRdataNext;
        end
    end

    // Combinational outputs are gated by rst so an aborted access drops its strobe immediately.
    logic issueStrobe;
    logic inAccess;
    logic respOut;

    assign issueStrobe = (stateReg == S_ISSUE) & ~mem_busy & ~rst;
    assign inAccess    = ((stateReg == S_ISSUE) | (stateReg == S_WAIT)) & ~rst;
    assign respOut     = (stateReg == S_RESP) & ~rst;

    assign mem_rd    = issueStrobe & ~opWrReg;
    assign mem_wr    = issueStrobe & opWrReg;
    assign mem_addr  = inAccess ? addrReg : 16'h0000;
    assign mem_wdata = (inAccess & opWrReg) ? wdataReg : 16'h0000;

    assign if_done  = respOut & ~ownerDataReg;
    assign dm_done  = respOut & ownerDataReg;
    assign if_err   = if_done & errReg;
    assign dm_err   = dm_done & errReg;
    assign if_rdata = ifRdataReg;
    assign dm_rdata = dmRdataReg;

    assign if_stall = if_req & ~if_done & ~rst;
    assign dm_stall = dataPending & ~dm_done & ~rst;
    assign halted   = halt & (stateReg == S_IDLE) & ~dataPending & ~rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-configurable memory responder plus a scoreboard
// of expected completions checked whenever either done pulse appears.
module tb_mem_arbiter;
    localparam int STREAK_MAX = 3;
    localparam int TIMEOUT    = 31;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = 16'h0;
    logic [15:0] if_rdata;
    logic        if_done, if_err, if_stall;
    logic        dm_rd = 1'b0, dm_wr = 1'b0;
    logic [15:0] dm_addr = 16'h0, dm_wdata = 16'h0;
    logic [15:0] dm_rdata;
    logic        dm_done, dm_err, dm_stall;
    logic        halt = 1'b0;
    logic        halted;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_rd, mem_wr;
    logic        mem_busy = 1'b0;
    logic        mem_done = 1'b0;
    logic [15:0] mem_rdata = 16'h0;

    mem_arbiter #(.STREAK_MAX(STREAK_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .if_err(if_err), .if_stall(if_stall),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_err(dm_err), .dm_stall(dm_stall),
        .halt(halt), .halted(halted),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit          isData;
        bit          err;
        logic [15:0] rdata;
        int          dueCyc;
    } expT;
    expT sbQ[$];
    expT curExp;

    logic [15:0] mm [logic [15:0]];
    int          memLat = 2;
    bit          withhold = 1'b0;
    int          countdown = -1;
    logic [15:0] pendAddr = 16'h0;
    int          strobeCnt = 0;
    int          strobeCyc = 0;
    logic [15:0] strobeAddr = 16'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] memRead(input logic [15:0] a);
        if (mm.exists(a)) return mm[a];
        return a ^ 16'h5A5A;
    endfunction

    always @(posedge clk) cyc++;

    // Memory responder: mem_done arrives memLat cycles after the strobe cycle.
    always @(posedge clk) begin
        #1;
        mem_done = 1'b0;
        if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
                mem_done  = 1'b1;
                mem_rdata = memRead(pendAddr);
                countdown = -1;
            end
        end
    end

    // Monitor: strobes and completions, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_rd | mem_wr) begin
            strobeCnt++;
            strobeCyc  = cyc;
            strobeAddr = mem_addr;
            check("strobe_while_busy", {31'b0, mem_busy}, 32'd0);
            if (mem_wr) mm[mem_addr] = mem_wdata;
            if (!withhold) begin
                countdown = memLat;
                pendAddr  = mem_addr;
            end
        end
        if (if_done | dm_done) begin
            check("done_both", {31'b0, if_done & dm_done}, 32'd0);
            if (sbQ.size() == 0) begin
                check("unexpected_done", {30'b0, if_done, dm_done}, 32'd0);
            end else begin
                curExp = sbQ.pop_front();
                $display("txn cyc=%0d owner=%s err=%b rdata=%h", cyc,
                         dm_done ? "data" : "fetch", dm_done ? dm_err : if_err,
                         dm_done ? dm_rdata : if_rdata);
                check("owner", {31'b0, dm_done}, {31'b0, curExp.isData});
                check("err", {31'b0, dm_done ? dm_err : if_err}, {31'b0, curExp.err});
                check("rdata", {16'b0, dm_done ? dm_rdata : if_rdata}, {16'b0, curExp.rdata});
                if (curExp.dueCyc >= 0) check("latency", cyc, curExp.dueCyc);
            end
        end
    end

    task automatic waitDrain(input int maxCyc, input string tag);
        for (int i = 0; i < maxCyc; i++) begin
            @(posedge clk);
            if (sbQ.size() == 0) break;
        end
        #1;
        check({tag, "_drain"}, sbQ.size(), 32'd0);
        sbQ.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s0;
        logic [15:0] expIf;
        logic [15:0] expDm;
        expIf = 16'h0;
        expDm = 16'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {23'b0, if_done, dm_done, if_err, dm_err, mem_rd, mem_wr,
                             halted, if_stall, dm_stall}, 32'd0);
        check("reset_rdata", {if_rdata, dm_rdata}, 32'd0);
        check("reset_addr", {16'b0, mem_addr}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: single fetch, L=2
        @(posedge clk); #1;
        memLat = 2; n = cyc; s0 = strobeCnt;
        if_req = 1'b1; if_addr = 16'h0010;
        expIf = memRead(16'h0010);
        sbQ.push_back('{isData: 1'b0, err: 1'b0, rdata: expIf, dueCyc: n + 4});
        @(negedge clk);
        check("t1_stall", {31'b0, if_stall}, 32'd1);
        waitDrain(20, "t1");
        if_req = 1'b0;
        check("t1_strobes", strobeCnt - s0, 32'd1);
        check("t1_addr", {16'b0, strobeAddr}, 32'h0010);
        check("t1_strobe_cyc", strobeCyc, n + 1);

        // 2: fetch and store both held -> D D D F, twice
        @(posedge clk); #1;
        memLat = 1; s0 = strobeCnt;
        if_req = 1'b1; if_addr = 16'h0100;
        dm_wr = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'hBEEF;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++)
                sbQ.push_back('{isData: 1'b1, err: 1'b0, rdata: expDm, dueCyc: -1});
            sbQ.push_back('{isData: 1'b0, err: 1'b0, rdata: 16'hBEEF, dueCyc: -1});
        end
        expIf = 16'hBEEF;
        waitDrain(200, "t2");
        if_req = 1'b0; dm_wr = 1'b0;
        check("t2_strobes", strobeCnt - s0, 32'd8);

        // 3: rejects (unaligned data, rd&wr, unaligned fetch)
        @(posedge clk); #1;
        s0 = strobeCnt; n = cyc;
        dm_rd = 1'b1; dm_addr = 16'h0003;
        sbQ.push_back('{isData: 1'b1, err: 1'b1, rdata: expDm, dueCyc: n + 1});
        waitDrain(10, "t3a");
        dm_rd = 1'b0;
        @(posedge clk); #1;
        n = cyc;
        dm_rd = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0200;
        sbQ.push_back('{isData: 1'b1, err: 1'b1, rdata: expDm, dueCyc: n + 1});
        waitDrain(10, "t3b");
        dm_rd = 1'b0; dm_wr = 1'b0;
        @(posedge clk); #1;
        n = cyc;
        if_req = 1'b1; if_addr = 16'h0011;
        sbQ.push_back('{isData: 1'b0, err: 1'b1, rdata: expIf, dueCyc: n + 1});
        waitDrain(10, "t3c");
        if_req = 1'b0;
        check("t3_strobes", strobeCnt - s0, 32'd0);

        // data load of the stored word, L=3
        @(posedge clk); #1;
        memLat = 3; n = cyc;
        dm_rd = 1'b1; dm_addr = 16'h0100;
        expDm = 16'hBEEF;
        sbQ.push_back('{isData: 1'b1, err: 1'b0, rdata: expDm, dueCyc: n + 5});
        waitDrain(20, "t3d");
        dm_rd = 1'b0;

        // 4: mem_busy held 5 cycles in ISSUE
        @(posedge clk); #1;
        memLat = 1; n = cyc; s0 = strobeCnt;
        mem_busy = 1'b1;
        if_req = 1'b1; if_addr = 16'h0030;
        expIf = memRead(16'h0030);
        sbQ.push_back('{isData: 1'b0, err: 1'b0, rdata: expIf, dueCyc: n + 8});
        repeat (6) @(posedge clk);
        #1 mem_busy = 1'b0;
        check("t4_no_strobe_busy", strobeCnt - s0, 32'd0);
        waitDrain(20, "t4");
        if_req = 1'b0;
        check("t4_strobes", strobeCnt - s0, 32'd1);
        check("t4_strobe_cyc", strobeCyc, n + 6);

        // 5: mem_done withheld -> timeout
        @(posedge clk); #1;
        withhold = 1'b1; n = cyc; s0 = strobeCnt;
        dm_rd = 1'b1; dm_addr = 16'h0020;
        sbQ.push_back('{isData: 1'b1, err: 1'b1, rdata: expDm, dueCyc: n + 2 + TIMEOUT});
        waitDrain(TIMEOUT + 20, "t5");
        dm_rd = 1'b0;
        withhold = 1'b0;
        check("t5_strobes", strobeCnt - s0, 32'd1);
        halt = 1'b1;
        @(negedge clk);
        check("t5_idle", {31'b0, halted}, 32'd1);
        @(posedge clk); #1 halt = 1'b0;

        // 6: reset mid-WAIT, late mem_done must be ignored
        @(posedge clk); #1;
        memLat = 6; s0 = strobeCnt;
        if_req = 1'b1; if_addr = 16'h0040;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; if_req = 1'b0;
        @(negedge clk);
        check("t6_rst_outs", {26'b0, if_done, dm_done, mem_rd, mem_wr, if_stall, dm_stall}, 32'd0);
        check("t6_rst_addr", {16'b0, mem_addr}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t6_rdata", {if_rdata, dm_rdata}, 32'd0);
        check("t6_strobes", strobeCnt - s0, 32'd1);
        expIf = 16'h0; expDm = 16'h0;

        // halt while idle blocks fetch; data still served; release lets fetch through
        @(posedge clk); #1;
        memLat = 1; s0 = strobeCnt;
        halt = 1'b1; if_req = 1'b1; if_addr = 16'h0050;
        @(negedge clk);
        check("halt_halted", {31'b0, halted}, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("halt_no_fetch", strobeCnt - s0, 32'd0);
        dm_rd = 1'b1; dm_addr = 16'h0100;
        expDm = 16'hBEEF;
        sbQ.push_back('{isData: 1'b1, err: 1'b0, rdata: expDm, dueCyc: -1});
        @(negedge clk);
        check("halt_data_pending", {31'b0, halted}, 32'd0);
        waitDrain(20, "halt_data");
        dm_rd = 1'b0;
        @(posedge clk); #1;
        n = cyc;
        halt = 1'b0;
        expIf = memRead(16'h0050);
        sbQ.push_back('{isData: 1'b0, err: 1'b0, rdata: expIf, dueCyc: n + 3});
        waitDrain(20, "unhalt");
        if_req = 1'b0;

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
